alu_share_arbiter: RTL and testbench

- Shares one instance of the single-cycle ALU between NUM_REQ requesters, for example an integer pipe and an address/branch unit.
- Round-robin arbitration; one operation in flight at a time.
- Operands are registered before the ALU and the result is registered after it, so the ALU sits on a clean reg-to-reg path.
- Per-requester valid/ready handshakes on both the request side and the response side.

---
 rtl/alu_share_arbiter_pkg.sv | 19 +
 rtl/alu.sv | 28 ++
 rtl/alu_share_arbiter_rr_pick.sv | 36 +++
 rtl/alu_share_arbiter.sv | 139 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter slice.
// Holds the ALU opcode encodings used by every ALU client and the
// arbiter FSM state encoding.
package alu_share_arbiter_pkg;

  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU.
// Ports:
//   a, b  : operands (WIDTH bits)
//   ctrl  : opcode (ALU_ADD / ALU_SUB / ALU_AND / ALU_OR)
//   y     : result; unlisted opcodes give 0. ADD/SUB wrap modulo 2^WIDTH.
module alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]      a,
  input  logic [WIDTH-1:0]      b,
  input  logic [ALU_CTRL_W-1:0] ctrl,
  output logic [WIDTH-1:0]      y
);

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_valid : per-requester valid
//   rr_ptr    : requester searched first; search wraps modulo NUM_REQ
//   grant     : one-hot winner
//   found     : any requester valid
//   idx       : binary index of the winner (0 when none)
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  // Outer loop walks priority order from rr_ptr; inner loop keeps every
  // bit index constant so no variable indexing is needed.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (!found && req_valid[k] && (k == (32'(rr_ptr) + off) % NUM_REQ)) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          idx      = ID_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin arbitration.
// Operands are registered before the ALU and the result after it; one
// operation is in flight at a time (IDLE -> EXEC -> RESP).
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   req_valid/req_a/req_b/req_ctrl : flattened per-requester requests
//   req_ready    : one-hot combinational accept strobe (IDLE only)
//   resp_valid   : one-hot response valid for the granted requester
//   resp_data    : registered ALU result
//   resp_ready   : per-requester response accept (only grant_id's bit used)
//   busy         : state != IDLE
//   grant_id     : index of requester owning the ALU
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ID_W    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_a,
  input  logic [NUM_REQ*DATA_W-1:0]    req_b,
  input  logic [NUM_REQ*ALU_CTRL_W-1:0] req_ctrl,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           resp_valid,
  output logic [DATA_W-1:0]            resp_data,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic                         busy,
  output logic [ID_W-1:0]              grant_id
);

  state_t                state_q,  state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]       grant_q,  grant_d;
  logic [DATA_W-1:0]     a_q,      a_d;
  logic [DATA_W-1:0]     b_q,      b_d;
  logic [ALU_CTRL_W-1:0] ctrl_q,   ctrl_d;
  logic [DATA_W-1:0]     result_q, result_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic                  pick_found;
  logic [ID_W-1:0]       pick_idx;
  logic [DATA_W-1:0]     alu_y;
  logic [NUM_REQ-1:0]    grant_oh;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .found     (pick_found),
    .idx       (pick_idx)
  );

  alu #(
    .WIDTH (DATA_W)
  ) u_alu (
    .a    (a_q),
    .b    (b_q),
    .ctrl (ctrl_q),
    .y    (alu_y)
  );

  always_comb begin
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant_oh[i] = (grant_q == ID_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    a_d       = a_q;
    b_d       = b_q;
    ctrl_d    = ctrl_q;
    result_d  = result_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        // Reset dominates: no accept strobe while reset is asserted.
        if (pick_found && !reset) begin
          req_ready = pick_grant;
          grant_d   = pick_idx;
          state_d   = ST_EXEC;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
              a_d    = req_a[i*DATA_W +: DATA_W];
              b_d    = req_b[i*DATA_W +: DATA_W];
              ctrl_d = req_ctrl[i*ALU_CTRL_W +: ALU_CTRL_W];
            end
          end
        end
      end
      ST_EXEC: begin
        result_d = alu_y;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (|(resp_ready & grant_oh)) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
    end
  end

  assign resp_valid = (state_q == ST_RESP) ? grant_oh : '0;
  assign resp_data  = result_q;
  assign busy       = (state_q != ST_IDLE);
  assign grant_id   = grant_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // NUM_REQ=2 instance
  logic [1:0]  v2, rdy2, rv2, rr2;
  logic [63:0] a2, b2;
  logic [7:0]  c2;
  logic [31:0] d2;
  logic        busy2;
  logic [1:0]  gid2;

  // NUM_REQ=4 instance
  logic [3:0]   v4, rdy4, rv4, rr4;
  logic [127:0] a4, b4;
  logic [15:0]  c4;
  logic [31:0]  d4;
  logic         busy4;
  logic [1:0]   gid4;

  int n_checks = 0;
  int n_fail   = 0;

  alu_share_arbiter #(.NUM_REQ(2), .DATA_W(32), .ID_W(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(v2), .req_a(a2), .req_b(b2),
    .req_ctrl(c2), .req_ready(rdy2), .resp_valid(rv2), .resp_data(d2),
    .resp_ready(rr2), .busy(busy2), .grant_id(gid2)
  );

  alu_share_arbiter #(.NUM_REQ(4), .DATA_W(32), .ID_W(2)) dut4 (
    .clk(clk), .reset(reset), .req_valid(v4), .req_a(a4), .req_b(b4),
    .req_ctrl(c4), .req_ready(rdy4), .resp_valid(rv4), .resp_data(d4),
    .resp_ready(rr4), .busy(busy4), .grant_id(gid4)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow a 1-unit settle.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set2(input int idx, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    a2[idx*32 +: 32] = a;
    b2[idx*32 +: 32] = b;
    c2[idx*4 +: 4]   = c;
  endtask

  // Single-requester operation on the 2-requester instance.
  task automatic run_op(input string tag, input int idx, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [31:0] exp);
    logic [1:0] oh;
    oh = 2'(1 << idx);
    set2(idx, a, b, c);
    v2 = oh;
    #1 check_eq({tag, "_req_ready"}, 64'(rdy2), 64'(oh));
    step();
    v2 = '0;
    step();
    #1;
    check_eq({tag, "_resp_valid"}, 64'(rv2), 64'(oh));
    check_eq({tag, "_data"}, 64'(d2), 64'(exp));
    check_eq({tag, "_grant_id"}, 64'(gid2), 64'(idx));
    rr2 = 2'b11;
    step();
    rr2 = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v2 = '0; a2 = '0; b2 = '0; c2 = '0; rr2 = '0;
    v4 = '0; a4 = '0; b4 = '0; c4 = '0; rr4 = '0;
    reset = 1'b1;
    step();
    step();
    #1;
    check_eq("rst_busy", 64'(busy2), 64'd0);
    check_eq("rst_resp_valid", 64'(rv2), 64'd0);
    check_eq("rst_grant_id", 64'(gid2), 64'd0);
    check_eq("rst_req_ready", 64'(rdy2), 64'd0);
    check_eq("rst_data", 64'(d2), 64'd0);
    reset = 1'b0;
    step();

    // Test 1: single op with per-cycle visibility
    set2(0, 32'd5, 32'd7, ALU_ADD);
    v2 = 2'b01;
    #1 check_eq("t1_req_ready", 64'(rdy2), 64'h1);
    step();
    v2 = '0;
    #1;
    check_eq("t1_exec_busy", 64'(busy2), 64'd1);
    check_eq("t1_exec_resp_valid", 64'(rv2), 64'd0);
    step();
    #1;
    check_eq("t1_resp_valid", 64'(rv2), 64'h1);
    check_eq("t1_data", 64'(d2), 64'd12);
    rr2 = 2'b01;
    step();
    rr2 = '0;
    #1;
    check_eq("t1_idle_busy", 64'(busy2), 64'd0);
    check_eq("t1_idle_resp_valid", 64'(rv2), 64'd0);

    // Test 2: wraparound, logic ops, invalid opcode; ends on requester 1 so rr_ptr=0
    run_op("t2_sub_wrap", 0, 32'd0, 32'd1, ALU_SUB, 32'hFFFF_FFFF);
    run_op("t2_add_wrap", 1, 32'hFFFF_FFFF, 32'd2, ALU_ADD, 32'h0000_0001);
    run_op("t2_bad_op", 0, 32'h1234, 32'h5678, 4'b0000, 32'd0);
    run_op("t2_and", 1, 32'h0000_F0F0, 32'h0000_0FF0, ALU_AND, 32'h0000_00F0);
    run_op("t2_or", 1, 32'h0000_F0F0, 32'h0000_0FF0, ALU_OR, 32'h0000_FFF0);

    // Test 3: round-robin under full contention
    set2(0, 32'd10, 32'd1, ALU_ADD);
    set2(1, 32'd100, 32'd50, ALU_SUB);
    v2 = 2'b11;
    rr2 = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 check_eq("t3_req_ready", 64'(rdy2), (k % 2 == 0) ? 64'h1 : 64'h2);
      step();
      #1 check_eq("t3_exec_req_ready", 64'(rdy2), 64'd0);
      step();
      #1;
      check_eq("t3_resp_valid", 64'(rv2), (k % 2 == 0) ? 64'h1 : 64'h2);
      check_eq("t3_grant_id", 64'(gid2), 64'(k % 2));
      check_eq("t3_data", 64'(d2), (k % 2 == 0) ? 64'd11 : 64'd50);
      step();
    end
    v2 = '0;
    rr2 = '0;

    // Test 4: response backpressure; rr_ptr=0 here
    set2(0, 32'd3, 32'd4, ALU_ADD);
    set2(1, 32'd9, 32'd1, ALU_SUB);
    v2 = 2'b01;
    #1 check_eq("t4_req_ready", 64'(rdy2), 64'h1);
    step();
    v2 = 2'b11;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("t4_hold_valid", 64'(rv2), 64'h1);
      check_eq("t4_hold_data", 64'(d2), 64'd7);
      check_eq("t4_hold_busy", 64'(busy2), 64'd1);
      check_eq("t4_hold_req_ready", 64'(rdy2), 64'd0);
      step();
    end
    rr2 = 2'b10;
    step();
    #1 check_eq("t4_other_ready_ignored", 64'(rv2), 64'h1);
    rr2 = 2'b01;
    step();
    rr2 = '0;
    #1 check_eq("t4_next_grant", 64'(rdy2), 64'h2);
    step();
    v2 = '0;
    step();
    #1;
    check_eq("t4_r1_valid", 64'(rv2), 64'h2);
    check_eq("t4_r1_data", 64'(d2), 64'd8);
    rr2 = 2'b11;
    step();
    rr2 = '0;

    // Test 5a: reset in EXEC after rr_ptr has been moved to 1
    run_op("t5_pre", 0, 32'd1, 32'd1, ALU_ADD, 32'd2);
    set2(1, 32'd40, 32'd2, ALU_ADD);
    v2 = 2'b10;
    #1 check_eq("t5a_req_ready", 64'(rdy2), 64'h2);
    step();
    v2 = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_eq("t5a_busy", 64'(busy2), 64'd0);
    check_eq("t5a_resp_valid", 64'(rv2), 64'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      #1 check_eq("t5a_no_stale", 64'(rv2), 64'd0);
    end
    set2(0, 32'd6, 32'd6, ALU_ADD);
    v2 = 2'b11;
    #1 check_eq("t5a_rr_ptr_zero", 64'(rdy2), 64'h1);
    step();
    v2 = '0;
    step();
    #1 check_eq("t5a_after_data", 64'(d2), 64'd12);
    rr2 = 2'b11;
    step();
    rr2 = '0;

    // Test 5b: reset in RESP (rr_ptr=1 now)
    v2 = 2'b10;
    #1 check_eq("t5b_req_ready", 64'(rdy2), 64'h2);
    step();
    v2 = '0;
    step();
    #1 check_eq("t5b_resp_valid", 64'(rv2), 64'h2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_eq("t5b_busy", 64'(busy2), 64'd0);
    check_eq("t5b_resp_valid_clr", 64'(rv2), 64'd0);
    step();
    #1 check_eq("t5b_no_stale", 64'(rv2), 64'd0);
    v2 = 2'b11;
    #1 check_eq("t5b_rr_ptr_zero", 64'(rdy2), 64'h1);
    step();
    v2 = '0;
    step();
    rr2 = 2'b11;
    step();
    rr2 = '0;

    // Test 6: NUM_REQ=4; move rr_ptr to 2 via requester 1, then contend 1 vs 3
    a4[1*32 +: 32] = 32'd1;  b4[1*32 +: 32] = 32'd1; c4[1*4 +: 4] = ALU_ADD;
    a4[3*32 +: 32] = 32'd20; b4[3*32 +: 32] = 32'd5; c4[3*4 +: 4] = ALU_OR;
    v4 = 4'b0010;
    #1 check_eq("t6_pre_ready", 64'(rdy4), 64'h2);
    step();
    v4 = '0;
    step();
    #1 check_eq("t6_pre_valid", 64'(rv4), 64'h2);
    rr4 = 4'b1111;
    step();
    v4 = 4'b1010;
    #1 check_eq("t6_first_r3", 64'(rdy4), 64'h8);
    step();
    step();
    #1;
    check_eq("t6_r3_valid", 64'(rv4), 64'h8);
    check_eq("t6_r3_grant", 64'(gid4), 64'd3);
    check_eq("t6_r3_data", 64'(d4), 64'd21);
    step();
    #1 check_eq("t6_then_r1", 64'(rdy4), 64'h2);
    step();
    v4 = '0;
    step();
    #1 check_eq("t6_r1_data", 64'(d4), 64'd2);
    step();
    rr4 = '0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
